// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches over req/ack, feeds the IF/ID register.
// Latency: 1 clock from imem_ack to DatoInstrD/DatoPCPlus4/valid; N-wait memory yields N bubbles first.
// Backpressure: stall freezes outputs; an ack arriving under stall is parked in a one-entry hold buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] DatoPCPlus4,
    output logic [31:0] DatoInstrD,
    output logic        valid,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // request outstanding at pc_q
        S_HOLD  = 2'd1,   // fetched word parked while stalled, no request
        S_DRAIN = 2'd2    // waiting out an abandoned request at req_addr_q
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic        advance;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // The IF/ID register only captures when the hazard unit is not stalling.
    assign advance  = ~stall;
    // Targets are word aligned; the low two bits are ignored.
    assign target   = redirect_pc & 32'hFFFF_FFFC;
    // Wraps modulo 2^32 with no overflow indication.
    assign pc_plus4 = pc_q + 32'd4;

    // Memory interface: a request is open in FETCH and DRAIN; DRAIN keeps the abandoned address stable.
    always_comb begin
        imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
        imem_addr = (state_q == S_DRAIN) ? req_addr_q : pc_q;
    end

    // Next-state and output-register update; redirect beats ack, ack beats stall.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;

        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    // Same-cycle data belongs to the wrong path and is dropped.
                    pc_d = target;
                    if (!imem_ack) begin
                        req_addr_d = pc_q;
                        state_d    = S_DRAIN;
                    end
                    if (advance) begin
                        instr_d = NOP;
                        valid_d = 1'b0;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_plus4;
                    if (advance) begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc4_d   = pc_plus4;
                        state_d     = S_HOLD;
                    end
                end else if (advance) begin
                    // Waiting on memory: emit a bubble, PC+4 output keeps its last value.
                    instr_d = NOP;
                    valid_d = 1'b0;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    // Parked word is on the wrong path; it is simply never emitted.
                    pc_d    = target;
                    state_d = S_FETCH;
                    if (advance) begin
                        instr_d = NOP;
                        valid_d = 1'b0;
                    end
                end else if (advance) begin
                    instr_d = buf_instr_q;
                    pc4_d   = buf_pc4_q;
                    valid_d = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_DRAIN: begin
                // A later redirect only retargets the PC; the old request must still complete.
                if (redirect) begin
                    pc_d = target;
                end
                // Response to the abandoned request is discarded; the PC already holds the target.
                if (imem_ack) begin
                    state_d = S_FETCH;
                end
                if (advance) begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State registers; reset opens a fetch at RESET_PC and clears all outputs and buffers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            req_addr_q  <= 32'h0000_0000;
            buf_instr_q <= 32'h0000_0000;
            buf_pc4_q   <= 32'h0000_0000;
            instr_q     <= NOP;
            pc4_q       <= 32'h0000_0000;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
        end
    end

    // Registered outputs toward IF/ID and the debug PC.
    always_comb begin
        DatoInstrD  = instr_q;
        DatoPCPlus4 = pc4_q;
        valid       = valid_q;
        pc          = pc_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus a reset-in-DRAIN sequence.
// Memory is modelled by the table itself: the acked word is always (expected address + 0x100).
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] DatoPCPlus4;
    logic [31:0] DatoInstrD;
    logic        valid;
    logic [31:0] pc;

    int checks;
    int errors;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP     (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .DatoPCPlus4(DatoPCPlus4),
        .DatoInstrD (DatoInstrD),
        .valid      (valid),
        .pc         (pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic r, input logic [31:0] rpc, input logic a,
                       input logic ereq, input logic [31:0] eaddr, input logic [31:0] einstr,
                       input logic [31:0] epc4, input logic ev);
        vec_t v;
        v.stall = s; v.redirect = r; v.rpc = rpc; v.ack = a;
        v.exp_req = ereq; v.exp_addr = eaddr; v.exp_instr = einstr;
        v.exp_pc4 = epc4; v.exp_valid = ev;
        vecs.push_back(v);
    endtask

    // Called at a negedge: drive one cycle, check request side, then outputs after the edge.
    task automatic step(input int idx, input vec_t v);
        stall       = v.stall;
        redirect    = v.redirect;
        redirect_pc = v.rpc;
        imem_ack    = v.ack;
        imem_rdata  = v.exp_addr + 32'h100;
        #1;
        chk($sformatf("c%0d imem_req", idx), {31'b0, imem_req}, {31'b0, v.exp_req});
        if (v.exp_req)
            chk($sformatf("c%0d imem_addr", idx), imem_addr, v.exp_addr);
        @(posedge clk);
        #1;
        chk($sformatf("c%0d DatoInstrD", idx), DatoInstrD, v.exp_instr);
        chk($sformatf("c%0d DatoPCPlus4", idx), DatoPCPlus4, v.exp_pc4);
        chk($sformatf("c%0d valid", idx), {31'b0, valid}, {31'b0, v.exp_valid});
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;

        //   stall redir rpc           ack  req addr          instr         pc4           valid
        // zero-wait stream
        add(0, 0, 32'h0,        1,   1, 32'h0,        32'h100,      32'h4,        1);
        add(0, 0, 32'h0,        1,   1, 32'h4,        32'h104,      32'h8,        1);
        add(0, 0, 32'h0,        1,   1, 32'h8,        32'h108,      32'hC,        1);
        add(0, 0, 32'h0,        1,   1, 32'hC,        32'h10C,      32'h10,       1);
        // 2-wait fetch: two bubbles, address stable
        add(0, 0, 32'h0,        0,   1, 32'h10,       32'h0,        32'h10,       0);
        add(0, 0, 32'h0,        0,   1, 32'h10,       32'h0,        32'h10,       0);
        add(0, 0, 32'h0,        1,   1, 32'h10,       32'h110,      32'h14,       1);
        // ack under stall -> HOLD for 3 cycles, then release
        add(1, 0, 32'h0,        1,   1, 32'h14,       32'h110,      32'h14,       1);
        add(1, 0, 32'h0,        0,   0, 32'h0,        32'h110,      32'h14,       1);
        add(1, 0, 32'h0,        0,   0, 32'h0,        32'h110,      32'h14,       1);
        add(0, 0, 32'h0,        0,   0, 32'h0,        32'h114,      32'h18,       1);
        add(0, 0, 32'h0,        1,   1, 32'h18,       32'h118,      32'h1C,       1);
        // redirect while a wait-state request is pending -> DRAIN
        add(0, 0, 32'h0,        0,   1, 32'h1C,       32'h0,        32'h1C,       0);
        add(0, 1, 32'h40,       0,   1, 32'h1C,       32'h0,        32'h1C,       0);
        add(0, 0, 32'h0,        0,   1, 32'h1C,       32'h0,        32'h1C,       0);
        add(0, 0, 32'h0,        1,   1, 32'h1C,       32'h0,        32'h1C,       0);
        add(0, 0, 32'h0,        1,   1, 32'h40,       32'h140,      32'h44,       1);
        // redirect + ack + stall in the same cycle
        add(1, 1, 32'h80,       1,   1, 32'h44,       32'h140,      32'h44,       1);
        add(1, 0, 32'h0,        0,   1, 32'h80,       32'h140,      32'h44,       1);
        add(0, 0, 32'h0,        1,   1, 32'h80,       32'h180,      32'h84,       1);
        // unaligned redirect near the top of memory, PC+4 wraps
        add(0, 1, 32'hFFFFFFFF, 0,   1, 32'h84,       32'h0,        32'h84,       0);
        add(0, 0, 32'h0,        1,   1, 32'h84,       32'h0,        32'h84,       0);
        add(0, 0, 32'h0,        1,   1, 32'hFFFFFFFC, 32'hFC,       32'h0,        1);
        add(0, 0, 32'h0,        1,   1, 32'h0,        32'h100,      32'h4,        1);
        // redirect out of HOLD discards the parked word
        add(1, 0, 32'h0,        1,   1, 32'h4,        32'h100,      32'h4,        1);
        add(0, 1, 32'h200,      0,   0, 32'h0,        32'h0,        32'h4,        0);
        add(0, 0, 32'h0,        1,   1, 32'h200,      32'h300,      32'h204,      1);
        // enter DRAIN, then reset below
        add(0, 1, 32'h300,      0,   1, 32'h204,      32'h0,        32'h204,      0);
        add(0, 0, 32'h0,        0,   1, 32'h204,      32'h0,        32'h204,      0);

        // Reset state
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        #1;
        chk("rst imem_req", {31'b0, imem_req}, 32'h1);
        chk("rst imem_addr", imem_addr, 32'h0);
        chk("rst DatoInstrD", DatoInstrD, 32'h0);
        chk("rst DatoPCPlus4", DatoPCPlus4, 32'h0);
        chk("rst valid", {31'b0, valid}, 32'h0);
        chk("rst pc", pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            step(i, v);
        end

        // Asynchronous reset while in DRAIN
        chk("drain pc", pc, 32'h300);
        rst = 1'b0;
        #1;
        chk("arst imem_req", {31'b0, imem_req}, 32'h1);
        chk("arst imem_addr", imem_addr, 32'h0);
        chk("arst DatoInstrD", DatoInstrD, 32'h0);
        chk("arst DatoPCPlus4", DatoPCPlus4, 32'h0);
        chk("arst valid", {31'b0, valid}, 32'h0);
        chk("arst pc", pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        v.stall = 0; v.redirect = 0; v.rpc = 32'h0; v.ack = 1;
        v.exp_req = 1; v.exp_addr = 32'h0; v.exp_instr = 32'h100;
        v.exp_pc4 = 32'h4; v.exp_valid = 1;
        step(100, v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
